// File: rtl/hood_mode_sched.sv
`default_nettype none
// ============================================================================
// Module      : hood_mode_sched
// Description : Mode scheduler for a cooker hood. Tracks the operating mode
//               (standby, menu, fan levels, timed hurricane boost, timed
//               level-3 run-down and timed self-clean) and derives the fan
//               speed. A seconds prescaler runs only in timed states.
// Ports       :
//   clk            in   1  system clock, rising edge
//   rst            in   1  asynchronous reset, active low
//   machine_state  in   1  1 = hood powered on, 0 = forced standby
//   menu_btn       in   1  single-cycle button pulse
//   lvl1_btn       in   1  single-cycle button pulse
//   lvl2_btn       in   1  single-cycle button pulse
//   lvl3_btn       in   1  single-cycle button pulse
//   clean_btn      in   1  single-cycle button pulse
//   fan_level      out  2  0 off, 1..3 fan speed
//   mode           out  3  current mode encoding
//   remaining      out  8  seconds left in a timed mode, else 0
//   hurricane_used out  1  hurricane already used this power-on session
//   clean_done     out  1  one-cycle pulse when self-clean completes
// Revision    : 1.0 - initial release
// ============================================================================
module hood_mode_sched #(
    parameter int SECOND        = 100_000_000,
    parameter int HURRICANE_SEC = 60,
    parameter int RETURN_SEC    = 60,
    parameter int CLEAN_SEC     = 180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       machine_state,
    input  logic       menu_btn,
    input  logic       lvl1_btn,
    input  logic       lvl2_btn,
    input  logic       lvl3_btn,
    input  logic       clean_btn,
    output logic [1:0] fan_level,
    output logic [2:0] mode,
    output logic [7:0] remaining,
    output logic       hurricane_used,
    output logic       clean_done
);

    localparam int PW = (SECOND > 1) ? $clog2(SECOND) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(SECOND - 1);
    localparam logic [7:0]    HURR_LOAD = 8'(HURRICANE_SEC);
    localparam logic [7:0]    RET_LOAD  = 8'(RETURN_SEC);
    localparam logic [7:0]    CLN_LOAD  = 8'(CLEAN_SEC);

    typedef enum logic [2:0] {
        ST_STANDBY   = 3'd0,
        ST_MENU      = 3'd1,
        ST_LEVEL1    = 3'd2,
        ST_LEVEL2    = 3'd3,
        ST_HURRICANE = 3'd4,
        ST_RETURN    = 3'd5,
        ST_CLEAN     = 3'd6
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   prescaler, prescaler_nxt;
    logic [7:0]      remaining_nxt;
    logic            hurricane_used_nxt;
    logic            clean_done_nxt;
    logic [1:0]      fan_level_nxt;
    logic            tick;
    logic            expiry;

    function automatic logic is_timed(input state_t s);
        return (s == ST_HURRICANE) || (s == ST_RETURN) || (s == ST_CLEAN);
    endfunction

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_STANDBY;
            prescaler      <= '0;
            remaining      <= 8'd0;
            hurricane_used <= 1'b0;
            clean_done     <= 1'b0;
            fan_level      <= 2'd0;
        end else begin
            state          <= state_nxt;
            prescaler      <= prescaler_nxt;
            remaining      <= remaining_nxt;
            hurricane_used <= hurricane_used_nxt;
            clean_done     <= clean_done_nxt;
            fan_level      <= fan_level_nxt;
        end
    end

    assign mode = state;

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt          = state;
        prescaler_nxt      = prescaler;
        remaining_nxt      = remaining;
        hurricane_used_nxt = hurricane_used;
        clean_done_nxt     = 1'b0;
        fan_level_nxt      = 2'd0;
        tick               = 1'b0;

        // Seconds prescaler advances only while a timer is running.
        if (is_timed(state)) begin
            if (prescaler == PRE_LAST) begin
                prescaler_nxt = '0;
                tick          = 1'b1;
            end else begin
                prescaler_nxt = prescaler + 1'b1;
            end
        end

        // Expiry is the tick that consumes the last second.
        expiry = tick && (remaining <= 8'd1);

        if (!machine_state) begin
            // Power-off overrides everything and ends the session.
            state_nxt          = ST_STANDBY;
            hurricane_used_nxt = 1'b0;
        end else begin
            unique case (state)
                ST_STANDBY: begin
                    if (menu_btn) state_nxt = ST_MENU;
                end
                ST_MENU: begin
                    if (clean_btn) begin
                        state_nxt     = ST_CLEAN;
                        remaining_nxt = CLN_LOAD;
                        prescaler_nxt = '0;
                    end else if (lvl3_btn) begin
                        // A used boost swallows the press: stay in the menu.
                        if (!hurricane_used) begin
                            state_nxt          = ST_HURRICANE;
                            remaining_nxt      = HURR_LOAD;
                            prescaler_nxt      = '0;
                            hurricane_used_nxt = 1'b1;
                        end
                    end else if (lvl2_btn) begin
                        state_nxt = ST_LEVEL2;
                    end else if (lvl1_btn) begin
                        state_nxt = ST_LEVEL1;
                    end else if (menu_btn) begin
                        state_nxt = ST_STANDBY;
                    end
                end
                ST_LEVEL1: begin
                    if (menu_btn)      state_nxt = ST_STANDBY;
                    else if (lvl2_btn) state_nxt = ST_LEVEL2;
                end
                ST_LEVEL2: begin
                    if (menu_btn)      state_nxt = ST_STANDBY;
                    else if (lvl1_btn) state_nxt = ST_LEVEL1;
                end
                ST_HURRICANE: begin
                    // Expiry beats a simultaneous menu press.
                    if (expiry) begin
                        state_nxt = ST_LEVEL2;
                    end else if (menu_btn) begin
                        state_nxt     = ST_RETURN;
                        remaining_nxt = RET_LOAD;
                        prescaler_nxt = '0;
                    end else if (tick) begin
                        remaining_nxt = remaining - 8'd1;
                    end
                end
                ST_RETURN: begin
                    if (expiry)    state_nxt     = ST_STANDBY;
                    else if (tick) remaining_nxt = remaining - 8'd1;
                end
                ST_CLEAN: begin
                    if (expiry) begin
                        state_nxt      = ST_STANDBY;
                        clean_done_nxt = 1'b1;
                    end else if (tick) begin
                        remaining_nxt = remaining - 8'd1;
                    end
                end
                default: begin
                    state_nxt = ST_STANDBY;
                end
            endcase
        end

        // Untimed destinations always start with a clean timer.
        if (!is_timed(state_nxt)) begin
            remaining_nxt = 8'd0;
            prescaler_nxt = '0;
        end

        unique case (state_nxt)
            ST_LEVEL1:    fan_level_nxt = 2'd1;
            ST_LEVEL2:    fan_level_nxt = 2'd2;
            ST_HURRICANE,
            ST_RETURN:    fan_level_nxt = 2'd3;
            default:      fan_level_nxt = 2'd0;
        endcase
    end

endmodule
`default_nettype wire
